// File: rtl/spart_pkg.sv
// Shared SPART definitions: BRG divisor-port addresses, baud select codes and
// the configuration controller state encoding.
package spart_pkg;

    localparam logic [1:0] BRG_ADDR_NONE = 2'b00;
    localparam logic [1:0] BRG_DB_LO     = 2'b10;
    localparam logic [1:0] BRG_DB_HI     = 2'b11;

    localparam logic [1:0] BAUD_4800  = 2'b00;
    localparam logic [1:0] BAUD_9600  = 2'b01;
    localparam logic [1:0] BAUD_19200 = 2'b10;
    localparam logic [1:0] BAUD_38400 = 2'b11;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_IDLE = 3'd1,
        WR_LO     = 3'd2,
        WR_HI     = 3'd3,
        DONE      = 3'd4,
        CPU_WR    = 3'd5
    } state_t;

endpackage

// File: rtl/brg_cfg_ctrl.sv
// BRG divisor configuration sequencer and write-port arbiter between the
// auto-config sequence (baud select -> two byte writes) and direct CPU byte writes.
module brg_cfg_ctrl
    import spart_pkg::*;
#(
    parameter logic [15:0] DIV_4800     = 16'd1301,
    parameter logic [15:0] DIV_9600     = 16'd650,
    parameter logic [15:0] DIV_19200    = 16'd325,
    parameter logic [15:0] DIV_38400    = 16'd162,
    parameter logic [15:0] IDLE_TIMEOUT = 16'd4096,
    parameter bit          AUTO_INIT    = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  baud_sel,
    input  logic        cfg_start,
    input  logic        line_idle,
    input  logic        cpu_req,
    input  logic        cpu_hi,
    input  logic [7:0]  cpu_data,
    output logic        cpu_ack,
    output logic [1:0]  brg_ioaddr,
    output logic [7:0]  brg_databus,
    output logic        cfg_busy,
    output logic        cfg_done,
    output logic        cfg_forced,
    output logic [15:0] cur_div,
    output state_t      dbg_state
);

    // CPU handshake: cpu_req is held with cpu_hi/cpu_data stable until cpu_ack;
    // cpu_ack pulses for one cycle while the byte is on the BRG port, and the
    // CPU must drop cpu_req in the following cycle.

    state_t      r_state;
    state_t      w_next;
    logic        r_auto_pend;
    logic [15:0] r_div;
    logic [15:0] r_cnt;
    logic        r_forced;
    logic [15:0] r_cur_div;
    logic        r_cpu_hi;
    logic [7:0]  r_cpu_byte;
    logic [15:0] w_lut_div;
    logic        w_timeout;
    logic        w_cfg_go;

    always_comb begin
        w_lut_div = DIV_9600;
        case (baud_sel)
            BAUD_4800:  w_lut_div = DIV_4800;
            BAUD_9600:  w_lut_div = DIV_9600;
            BAUD_19200: w_lut_div = DIV_19200;
            BAUD_38400: w_lut_div = DIV_38400;
            default:    w_lut_div = DIV_9600;
        endcase
    end

    // Auto-init is treated as a cfg_start presented on the first edge after reset.
    assign w_cfg_go  = cfg_start || r_auto_pend;
    assign w_timeout = (r_cnt == (IDLE_TIMEOUT - 16'd1));

    always_ff @(posedge clk) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_cfg_go)     w_next = WAIT_IDLE;
                else if (cpu_req) w_next = CPU_WR;
            end
            WAIT_IDLE: if (line_idle || w_timeout) w_next = WR_LO;
            WR_LO:     w_next = WR_HI;
            WR_HI:     w_next = DONE;
            DONE:      w_next = IDLE;
            CPU_WR:    w_next = IDLE;
            default:   w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_auto_pend <= AUTO_INIT;
            r_div       <= DIV_9600;
            r_cnt       <= 16'd0;
            r_forced    <= 1'b0;
            r_cur_div   <= DIV_9600;
            r_cpu_hi    <= 1'b0;
            r_cpu_byte  <= 8'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_cfg_go) begin
                        r_div       <= w_lut_div;
                        r_cnt       <= 16'd0;
                        r_forced    <= 1'b0;
                        r_auto_pend <= 1'b0;
                    end else if (cpu_req) begin
                        r_cpu_hi   <= cpu_hi;
                        r_cpu_byte <= cpu_data;
                        if (cpu_hi) r_cur_div[15:8] <= cpu_data;
                        else        r_cur_div[7:0]  <= cpu_data;
                    end
                end
                WAIT_IDLE: begin
                    if (!line_idle) begin
                        if (w_timeout)              r_forced <= 1'b1;
                        else if (r_cnt != 16'hFFFF) r_cnt    <= r_cnt + 16'd1;
                    end
                end
                WR_HI:   r_cur_div <= r_div;
                default: ;
            endcase
        end
    end

    // BRG port is decoded purely from registered state.
    always_comb begin
        brg_ioaddr  = BRG_ADDR_NONE;
        brg_databus = 8'd0;
        case (r_state)
            WR_LO: begin
                brg_ioaddr  = BRG_DB_LO;
                brg_databus = r_div[7:0];
            end
            WR_HI: begin
                brg_ioaddr  = BRG_DB_HI;
                brg_databus = r_div[15:8];
            end
            CPU_WR: begin
                brg_ioaddr  = r_cpu_hi ? BRG_DB_HI : BRG_DB_LO;
                brg_databus = r_cpu_byte;
            end
            default: ;
        endcase
    end

    assign cpu_ack    = (r_state == CPU_WR);
    assign cfg_done   = (r_state == DONE);
    assign cfg_busy   = (r_state != IDLE);
    assign cfg_forced = r_forced;
    assign cur_div    = r_cur_div;
    assign dbg_state  = r_state;

endmodule

// File: doc/brg_cfg_ctrl.md
Name: brg_cfg_ctrl

Overview:
- Configuration controller and write-port arbiter for the SPART baud rate generator's divisor programming interface (BRG ioaddr/databus: 2'b10 loads DB low byte, 2'b11 loads DB high byte).
- Translates a 2-bit baud select into a 16-bit divisor and writes it as two byte cycles.
- Defers reprogramming until the serial line is idle, with a timeout.
- Shares the BRG port between this auto-config sequencer and direct CPU byte writes.

Parameters:
- DIV_4800, 16'd1301, divisor for baud_sel=00 (100 MHz, 16x oversample: round(CLK/(16*baud))-1)
- DIV_9600, 16'd650, divisor for baud_sel=01 (matches BRG reset default)
- DIV_19200, 16'd325, divisor for baud_sel=10
- DIV_38400, 16'd162, divisor for baud_sel=11
- IDLE_TIMEOUT, 16'd4096, max cycles in WAIT_IDLE before a forced write
- AUTO_INIT, 1, 1 = run one config sequence automatically after reset

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-low
- baud_sel  in  2  baud select, sampled when a config sequence is accepted
- cfg_start  in  1  one-cycle pulse: reprogram BRG from baud_sel
- line_idle  in  1  high when TX and RX are both idle
- cpu_req  in  1  CPU divisor byte write request; held until cpu_ack
- cpu_hi  in  1  0 = low byte, 1 = high byte
- cpu_data  in  8  CPU byte
- cpu_ack  out  1  one-cycle ack, asserted in the cycle the CPU byte is driven to the BRG
- brg_ioaddr  out  2  to BRG ioaddr
- brg_databus  out  8  to BRG databus
- cfg_busy  out  1  high in every state except IDLE
- cfg_done  out  1  one-cycle pulse when an auto-config sequence completes
- cfg_forced  out  1  sticky; set when a write was forced by timeout, cleared by the next cfg_start
- cur_div  out  16  shadow copy of the divisor last written to the BRG

Behaviour:
- Reset (rst==0 at posedge):
  - state = IDLE (or WAIT_IDLE if AUTO_INIT=1, using baud_sel at that edge once rst releases).
  - brg_ioaddr = 2'b00, brg_databus = 0, cpu_ack = 0, cfg_done = 0, cfg_forced = 0, cur_div = 16'd650, timeout counter = 0.
  - Reset mid-sequence abandons it; the BRG resets to 650 in parallel, so cur_div stays consistent.
- Outputs are Moore-decoded from the state register; no combinational path from inputs to brg_*.
- In IDLE, WAIT_IDLE and DONE, the block drives brg_ioaddr = 2'b00 (never 10/11).
- States:
  - IDLE:
    - cfg_start=1: latch div_sel = LUT(baud_sel), clear cfg_forced, clear counter -> WAIT_IDLE.
    - else cpu_req=1: latch cpu_hi/cpu_data -> CPU_WR.
    - cfg_start and cpu_req in the same cycle: cfg wins; the CPU waits (cpu_ack low) and is served on return to IDLE.
  - WAIT_IDLE:
    - line_idle=1 -> WR_LO.
    - else counter+1; when counter == IDLE_TIMEOUT-1, set cfg_forced -> WR_LO.
    - cfg_start ignored.
  - WR_LO: brg_ioaddr=10, brg_databus=div[7:0], one cycle -> WR_HI.
  - WR_HI: brg_ioaddr=11, brg_databus=div[15:8], one cycle -> DONE.
  - DONE: cur_div = div, cfg_done=1 for one cycle -> IDLE.
  - CPU_WR:
    - brg_ioaddr = cpu_hi ? 11 : 10, brg_databus = latched byte, cpu_ack=1.
    - Update the matching cur_div byte -> IDLE.
    - cfg_start arriving in CPU_WR is lost; the requester must re-pulse after cfg_busy falls.
- Latency, cfg_start to cfg_done with line_idle high: 4 cycles (start at edge N; WAIT_IDLE N+1, WR_LO N+2, WR_HI N+3, DONE N+4).
- Latency, cpu_req in IDLE to cpu_ack: 1 cycle.
- cpu_req held across the ack cycle is treated as a new request only after returning to IDLE. The CPU must drop cpu_req the cycle after the ack.
- Timeout counter is 16-bit and saturates; it never wraps.

Decomposition:
- Package spart_pkg holds:
  - BRG address constants (BRG_ADDR_NONE=2'b00, BRG_DB_LO=2'b10, BRG_DB_HI=2'b11).
  - Baud select encodings.
  - The state enum (IDLE, WAIT_IDLE, WR_LO, WR_HI, DONE, CPU_WR).
- No sub-module needed. The baud LUT is an inline case; a separate brg_div_lut adds nothing.

Test Plan:
- rst low 2 cycles, AUTO_INIT=1, baud_sel=01, line_idle=1 -> brg_ioaddr 10/8'h8A then 11/8'h02, cfg_done on cycle 4 after release, cur_div=650.
- cfg_start with baud_sel=11, line_idle=1 -> writes 8'hA2 then 8'h00, cfg_done 4 cycles later, cur_div=162, cfg_forced=0.
- cfg_start with baud_sel=00, line_idle held 0 -> no 10/11 address for IDLE_TIMEOUT cycles, then 8'h15 and 8'h05 written, cfg_forced=1; the next cfg_start clears it.
- cpu_req and cfg_start in the same cycle, cpu_hi=1, cpu_data=8'h7F -> cfg sequence completes first; cpu_ack is one cycle after return to IDLE, with brg_ioaddr=11/8'h7F and cur_div[15:8]=8'h7F.
- rst asserted during WR_LO of a baud_sel=10 sequence -> next cycle brg_ioaddr=00, cfg_busy=0, cur_div=650, no cfg_done.
- Checker, every cycle: brg_ioaddr is 10/11 only in WR_LO, WR_HI or CPU_WR, and cpu_ack coincides exactly with CPU_WR.
